// File: rtl/alu_pkg.sv
// Shared decode constants and MDU state encoding for alu_ctrl_mdu.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OTHER = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b100;
  localparam logic [2:0] ALUC_SLT = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  // mult/multu/div/divu share the 0110xx pattern; bit0 = unsigned, bit1 = divide
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider core.
// prod/quot/rem present the value after the current cycle's step, so the
// caller can commit the result on the same edge as the final iteration.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done_iter,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  // lo_q: multiplier / dividend shifting into quotient; hi_q: product high / remainder
  logic [WIDTH-1:0] lo_q, hi_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   rsh;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  logic             unused_diff;

  always_comb begin
    b_sel    = lo_q[0] ? b_q : '0;
    mul_sum  = {1'b0, hi_q} + {1'b0, b_sel};
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    rsh      = {hi_q, lo_q[WIDTH-1]};
    diff     = {1'b0, rsh} - {2'b00, b_q};
    fits     = ~diff[WIDTH+1];
    // remainder always fits WIDTH bits: it stays below the divisor
    div_hi_n = fits ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
    div_lo_n = {lo_q[WIDTH-2:0], fits};
  end

  assign unused_diff = diff[WIDTH];
  assign prod        = {mul_hi_n, mul_lo_n};
  assign quot        = div_lo_n;
  assign rem         = div_hi_n;
  assign done_iter   = step && (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      lo_q  <= op_a;
      hi_q  <= '0;
      b_q   <= op_b;
      cnt_q <= '0;
      div_q <= is_div;
    end else if (step) begin
      lo_q  <= div_q ? div_lo_n : mul_lo_n;
      hi_q  <= div_q ? div_hi_n : mul_hi_n;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder plus multi-cycle multiply/divide unit with HI/LO.
// Handles signs around an unsigned iterative core and stalls the datapath.
module alu_ctrl_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       ALUControl,
  output logic             mdu_sel,
  output logic [WIDTH-1:0] mdu_result,
  output logic             stall,
  output logic             div_by_zero
);

  mdu_state_e state_q, state_n;

  logic             md_live, is_md, is_signed, is_div;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             load, step, done_iter;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot, rem, quot_fix, rem_fix;
  logic [WIDTH-1:0] hi_q, lo_q, a_orig_q;
  logic             neg_q, rneg_q, bzero_q, div_q, dbz_q;

  always_comb begin
    ALUControl = ALUC_ADD;
    case (ALUOp)
      ALUOP_ADD:   ALUControl = ALUC_ADD;
      ALUOP_SUB:   ALUControl = ALUC_SUB;
      ALUOP_RTYPE: begin
        case (Funct)
          F_ADD:   ALUControl = ALUC_ADD;
          F_SUB:   ALUControl = ALUC_SUB;
          F_AND:   ALUControl = ALUC_AND;
          F_OR:    ALUControl = ALUC_OR;
          F_SLT:   ALUControl = ALUC_SLT;
          default: ALUControl = ALUC_ADD;
        endcase
      end
      default:     ALUControl = ALUC_ADD;
    endcase
  end

  assign md_live   = valid && (ALUOp == ALUOP_RTYPE);
  assign is_md     = md_live && is_muldiv(Funct);
  assign is_signed = ~Funct[0];
  assign is_div    = Funct[1];
  assign neg_a     = is_signed & src_a[WIDTH-1];
  assign neg_b     = is_signed & src_b[WIDTH-1];
  assign mag_a     = neg_a ? -src_a : src_a;
  assign mag_b     = neg_b ? -src_b : src_b;

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: if (is_md) begin
        load    = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (done_iter) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    stall = ~reset && (load || state_q == S_RUN);
  end

  mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .is_div    (is_div),
    .op_a      (mag_a),
    .op_b      (mag_b),
    .done_iter (done_iter),
    .prod      (prod),
    .quot      (quot),
    .rem       (rem)
  );

  // -MIN / -1 needs no special case: |MIN| quotient with no negate wraps to MIN
  assign prod_fix = neg_q  ? -prod : prod;
  assign quot_fix = neg_q  ? -quot : quot;
  assign rem_fix  = rneg_q ? -rem  : rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      a_orig_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      div_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      if (load) begin
        neg_q    <= neg_a ^ neg_b;
        rneg_q   <= neg_a;
        a_orig_q <= src_a;
        bzero_q  <= (src_b == '0);
        div_q    <= is_div;
        dbz_q    <= 1'b0;
      end
      if (done_iter) begin
        if (!div_q) begin
          {hi_q, lo_q} <= prod_fix;
        end else if (bzero_q) begin
          lo_q  <= '1;
          hi_q  <= a_orig_q;
          dbz_q <= 1'b1;
        end else begin
          lo_q <= quot_fix;
          hi_q <= rem_fix;
        end
      end else if (state_q == S_IDLE && md_live) begin
        if (Funct == F_MTHI) hi_q <= src_a;
        if (Funct == F_MTLO) lo_q <= src_a;
      end
    end
  end

  assign div_by_zero = dbz_q;
  assign mdu_sel     = ~reset && md_live && (state_q != S_RUN) &&
                       (Funct == F_MFHI || Funct == F_MFLO);
  assign mdu_result  = !mdu_sel ? '0 : (Funct == F_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: decode table, directed MDU cases,
// reset abort, mthi/mtlo, and randomized ops against an arithmetic model.
module tb_alu_ctrl_mdu;

  logic        clk = 1'b0;
  logic        reset, valid;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [31:0] src_a, src_b;
  logic [2:0]  ALUControl;
  logic        mdu_sel, stall, div_by_zero;
  logic [31:0] mdu_result;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m = 0, lo_m = 0;
  logic        dz_m = 0;

  alu_ctrl_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp), .Funct(Funct),
    .src_a(src_a), .src_b(src_b), .ALUControl(ALUControl), .mdu_sel(mdu_sel),
    .mdu_result(mdu_result), .stall(stall), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the architectural rules
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint la, lb;
    logic [63:0] p;
    sa = a; sb = b; la = sa; lb = sb;
    dz_m = 1'b0;
    case (f)
      6'b011000: begin p = la * lb; {hi_m, lo_m} = p; end
      6'b011001: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; end
      default: begin
        if (b == 0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = a; dz_m = 1'b1;
        end else if (f == 6'b011011) begin
          lo_m = a / b; hi_m = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = 0;
        end else begin
          lo_m = sa / sb; hi_m = sa % sb;
        end
      end
    endcase
  endtask

  task automatic read_hilo(input string tag);
    Funct = 6'b010000; valid = 1; ALUOp = 2'b10;
    #1;
    check({tag, " mfhi sel"}, mdu_sel, 1);
    check({tag, " mfhi"}, mdu_result, hi_m);
    Funct = 6'b010010;
    #1;
    check({tag, " mflo"}, mdu_result, lo_m);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int n;
    bit done;
    @(negedge clk);
    valid = 1; ALUOp = 2'b10; Funct = f; src_a = a; src_b = b;
    n = 0; done = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stall) n++;
      else begin done = 1; break; end
      @(negedge clk);
    end
    check({tag, " completed"}, done, 1);
    check({tag, " stall cycles"}, n, 33);
    model(f, a, b);
    check({tag, " div_by_zero"}, div_by_zero, dz_m);
    @(negedge clk);
    read_hilo(tag);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [2:0] exp;
  } dec_vec_t;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } md_vec_t;

  dec_vec_t dv[14];
  md_vec_t  mv[6];

  initial begin
    dv[0]  = '{2'b00, 6'b101010, 3'b010};
    dv[1]  = '{2'b00, 6'b000000, 3'b010};
    dv[2]  = '{2'b01, 6'b100000, 3'b100};
    dv[3]  = '{2'b01, 6'b101010, 3'b100};
    dv[4]  = '{2'b10, 6'b100000, 3'b010};
    dv[5]  = '{2'b10, 6'b100010, 3'b100};
    dv[6]  = '{2'b10, 6'b100100, 3'b000};
    dv[7]  = '{2'b10, 6'b100101, 3'b001};
    dv[8]  = '{2'b10, 6'b101010, 3'b110};
    dv[9]  = '{2'b10, 6'b000000, 3'b010};
    dv[10] = '{2'b10, 6'b011000, 3'b010};
    dv[11] = '{2'b10, 6'b111111, 3'b010};
    dv[12] = '{2'b11, 6'b100010, 3'b010};
    dv[13] = '{2'b11, 6'b100100, 3'b010};

    mv[0] = '{6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    mv[1] = '{6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    mv[2] = '{6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    mv[3] = '{6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
    mv[4] = '{6'b011010, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1};
    mv[5] = '{6'b011001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0};

    reset = 1; valid = 0; ALUOp = 0; Funct = 0; src_a = 0; src_b = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    check("reset stall", stall, 0);
    check("reset div_by_zero", div_by_zero, 0);
    check("reset mdu_sel", mdu_sel, 0);
    check("reset mdu_result", mdu_result, 0);
    read_hilo("reset");

    // decode sweep with valid low so nothing starts
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      valid = 0; ALUOp = dv[i].op; Funct = dv[i].f;
      #1;
      check($sformatf("decode[%0d] ALUControl", i), ALUControl, dv[i].exp);
      check($sformatf("decode[%0d] stall", i), stall, 0);
    end

    for (int i = 0; i < 6; i++) begin
      run_op(mv[i].f, mv[i].a, mv[i].b, $sformatf("dir[%0d]", i));
      check($sformatf("dir[%0d] const hi", i), hi_m, mv[i].hi);
      check($sformatf("dir[%0d] const lo", i), lo_m, mv[i].lo);
      check($sformatf("dir[%0d] const dz", i), dz_m, mv[i].dz);
    end

    // reset in RUN cycle 10 aborts, then a re-issue completes
    @(negedge clk);
    valid = 1; ALUOp = 2'b10; Funct = 6'b011000; src_a = 32'd1234567; src_b = 32'd89;
    repeat (10) @(negedge clk);
    #1;
    check("abort pre stall", stall, 1);
    reset = 1; valid = 0;
    @(negedge clk);
    reset = 0;
    #1;
    check("abort stall", stall, 0);
    check("abort div_by_zero", div_by_zero, 0);
    hi_m = 0; lo_m = 0;
    read_hilo("abort");
    run_op(6'b011000, 32'd1234567, 32'd89, "reissue");

    // mthi then mfhi back to back, mtlo with valid low has no effect
    @(negedge clk);
    valid = 1; ALUOp = 2'b10; Funct = 6'b010001; src_a = 32'h1234;
    #1;
    check("mthi stall", stall, 0);
    hi_m = 32'h1234;
    @(negedge clk);
    Funct = 6'b010000;
    #1;
    check("mfhi after mthi sel", mdu_sel, 1);
    check("mfhi after mthi", mdu_result, 32'h1234);
    check("mfhi stall", stall, 0);
    @(negedge clk);
    valid = 0; Funct = 6'b010011; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    read_hilo("mtlo invalid");
    @(negedge clk);
    valid = 1; Funct = 6'b010011; src_a = 32'hCAFE_0001;
    lo_m = 32'hCAFE_0001;
    @(negedge clk);
    read_hilo("mtlo");

    for (int i = 0; i < 16; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      int sel;
      f   = 6'b011000 + 6'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 5);
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 2) a = -32'd1 - 32'($urandom_range(0, 3));
      run_op(f, a, b, $sformatf("rand[%0d]", i));
    end

    @(negedge clk);
    valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
